// File: rtl/vend_timer_sched.sv
// vend_timer_sched: four independent countdown channels driven by one shared
// tick prescaler. Each channel loads a duration in ticks, counts down on
// every tick, and emits a one-cycle expire pulse when it reaches zero.
// Cancel aborts a channel silently. A start while every channel is idle
// restarts the prescaler, so the first tick falls a full DIV cycles after it.
module vend_timer_sched #(
    parameter int unsigned DIV = 50000000,
    parameter int unsigned CW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      start,
    input  logic [3:0]      cancel,
    input  logic [4*CW-1:0] dur,
    output logic [3:0]      busy,
    output logic [3:0]      expire,
    output logic [4*CW-1:0] remain,
    output logic            tick
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_ZERO = PW'(1'b0);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1'b1);
    localparam logic [CW-1:0] REM_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] REM_ONE  = CW'(1'b1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    // Prescaler state
    logic [PW-1:0] r_pre;
    logic [PW-1:0] w_pre_nxt;
    logic          r_tick;
    logic          w_restart;

    // Channel state
    ch_state_t     r_state      [4];
    ch_state_t     w_state_nxt  [4];
    logic [CW-1:0] r_remain     [4];
    logic [CW-1:0] w_remain_nxt [4];
    logic [3:0]    r_expire;
    logic [3:0]    w_expire_nxt;
    logic [3:0]    w_busy;

    // Decode which channels are currently in RUN.
    always_comb begin
        w_busy = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            w_busy[n] = (r_state[n] == ST_RUN);
        end
    end

    // Next prescaler value: restart on a start from all-idle, otherwise wrap 0..DIV-1.
    always_comb begin
        w_restart = (w_busy == 4'b0000) && (start != 4'b0000);
        w_pre_nxt = PRE_ZERO;
        if (w_restart) begin
            w_pre_nxt = PRE_ZERO;
        end else if (r_pre == PRE_MAX) begin
            w_pre_nxt = PRE_ZERO;
        end else begin
            w_pre_nxt = r_pre + PRE_ONE;
        end
    end

    // Prescaler register; tick is registered so it is high while the counter sits at DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre  <= PRE_ZERO;
            r_tick <= 1'b0;
        end else begin
            r_pre  <= w_pre_nxt;
            r_tick <= (w_pre_nxt == PRE_MAX);
        end
    end

    // Per-channel next state: cancel beats start, start beats tick, tick only affects RUN.
    always_comb begin
        w_expire_nxt = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            w_state_nxt[n]  = r_state[n];
            w_remain_nxt[n] = r_remain[n];
            if (cancel[n]) begin
                w_state_nxt[n]  = ST_IDLE;
                w_remain_nxt[n] = REM_ZERO;
            end else if (start[n]) begin
                if (dur[n*CW +: CW] != REM_ZERO) begin
                    w_state_nxt[n]  = ST_RUN;
                    w_remain_nxt[n] = dur[n*CW +: CW];
                end else begin
                    // Zero duration times out immediately without ever running.
                    w_state_nxt[n]  = ST_IDLE;
                    w_remain_nxt[n] = REM_ZERO;
                    w_expire_nxt[n] = 1'b1;
                end
            end else begin
                case (r_state[n])
                    ST_RUN: begin
                        if (r_tick) begin
                            // Treat a stray zero like one so the count can never wrap.
                            if (r_remain[n] <= REM_ONE) begin
                                w_state_nxt[n]  = ST_IDLE;
                                w_remain_nxt[n] = REM_ZERO;
                                w_expire_nxt[n] = 1'b1;
                            end else begin
                                w_state_nxt[n]  = ST_RUN;
                                w_remain_nxt[n] = r_remain[n] - REM_ONE;
                            end
                        end else begin
                            w_state_nxt[n]  = ST_RUN;
                            w_remain_nxt[n] = r_remain[n];
                        end
                    end
                    ST_IDLE: begin
                        w_state_nxt[n]  = ST_IDLE;
                        w_remain_nxt[n] = REM_ZERO;
                    end
                    default: begin
                        w_state_nxt[n]  = ST_IDLE;
                        w_remain_nxt[n] = REM_ZERO;
                    end
                endcase
            end
        end
    end

    // Channel state, remaining count and expire pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                r_state[n]  <= ST_IDLE;
                r_remain[n] <= REM_ZERO;
            end
            r_expire <= 4'b0000;
        end else begin
            for (int n = 0; n < 4; n++) begin
                r_state[n]  <= w_state_nxt[n];
                r_remain[n] <= w_remain_nxt[n];
            end
            r_expire <= w_expire_nxt;
        end
    end

    // Pack the per-channel registers onto the output ports.
    always_comb begin
        remain = '0;
        for (int n = 0; n < 4; n++) begin
            remain[n*CW +: CW] = r_remain[n];
        end
    end

    assign busy   = w_busy;
    assign expire = r_expire;
    assign tick   = r_tick;

endmodule

// File: tb/tb_vend_timer_sched.sv
// Directed testbench for vend_timer_sched with DIV=4, CW=8.
// Cycle k means k clock edges after the cycle in which start was driven.
module tb_vend_timer_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start;
    logic [3:0]  cancel;
    logic [31:0] dur;
    logic [3:0]  busy;
    logic [3:0]  expire;
    logic [31:0] remain;
    logic        tick;

    int n_checks = 0;
    int n_pass   = 0;

    vend_timer_sched #(.DIV(4), .CW(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cancel (cancel),
        .dur    (dur),
        .busy   (busy),
        .expire (expire),
        .remain (remain),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 4'b0; cancel = 4'b0; dur = 32'h0;
        cyc(); cyc();
        n_checks++;
        if ({busy, expire, remain, tick} !== 41'h0)
            $display("FAIL reset_outputs busy=%b expire=%b remain=%h tick=%b expected all zero", busy, expire, remain, tick);
        else n_pass++;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        logic       e_tick, e_busy;
        logic [3:0] e_exp;
        logic [7:0] e_rem;
        dur[7:0] = 8'd2; start = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 1) start = 4'b0;
            e_tick = (k == 4) || (k == 8);
            e_busy = (k < 9);
            e_exp  = (k == 9) ? 4'b0001 : 4'b0000;
            e_rem  = (k <= 4) ? 8'd2 : ((k <= 8) ? 8'd1 : 8'd0);
            n_checks++;
            if (tick !== e_tick) $display("FAIL basic_tick k=%0d got %b expected %b", k, tick, e_tick);
            else n_pass++;
            n_checks++;
            if (busy[0] !== e_busy) $display("FAIL basic_busy k=%0d got %b expected %b", k, busy[0], e_busy);
            else n_pass++;
            n_checks++;
            if (expire !== e_exp) $display("FAIL basic_expire k=%0d got %b expected %b", k, expire, e_exp);
            else n_pass++;
            n_checks++;
            if (remain[7:0] !== e_rem) $display("FAIL basic_remain k=%0d got %0d expected %0d", k, remain[7:0], e_rem);
            else n_pass++;
        end
    endtask

    task automatic test_zero();
        dur[15:8] = 8'd0; start = 4'b0010;
        cyc(); start = 4'b0;
        n_checks++;
        if (expire !== 4'b0010) $display("FAIL zero_expire got %b expected 0010", expire);
        else n_pass++;
        n_checks++;
        if (busy !== 4'b0000) $display("FAIL zero_busy got %b expected 0000", busy);
        else n_pass++;
        cyc();
        n_checks++;
        if (expire !== 4'b0000) $display("FAIL zero_expire_end got %b expected 0000", expire);
        else n_pass++;
        cyc();
    endtask

    task automatic test_priority();
        int bad;
        // Cancel and start together on a running channel.
        dur[23:16] = 8'd5; start = 4'b0100;
        cyc(); start = 4'b0;
        n_checks++;
        if (busy[2] !== 1'b1) $display("FAIL prio_ch2_run got %b expected 1", busy[2]);
        else n_pass++;
        cancel = 4'b0100; start = 4'b0100;
        cyc(); cancel = 4'b0; start = 4'b0;
        n_checks++;
        if (busy[2] !== 1'b0 || remain[23:16] !== 8'd0 || expire !== 4'b0)
            $display("FAIL prio_cancel busy=%b remain=%0d expire=%b expected 0/0/0000", busy[2], remain[23:16], expire);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (expire !== 4'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL prio_no_expire got %0d expire cycles expected 0", bad);
        else n_pass++;
        // Start coincident with tick reloads without decrementing.
        dur[31:24] = 8'd3; start = 4'b1000;
        cyc(); start = 4'b0;
        cyc(); cyc(); cyc();
        n_checks++;
        if (tick !== 1'b1 || remain[31:24] !== 8'd3)
            $display("FAIL prio_pre_tick tick=%b remain=%0d expected 1/3", tick, remain[31:24]);
        else n_pass++;
        dur[31:24] = 8'd6; start = 4'b1000;
        cyc(); start = 4'b0;
        n_checks++;
        if (remain[31:24] !== 8'd6) $display("FAIL prio_start_tick got %0d expected 6", remain[31:24]);
        else n_pass++;
        cyc(); cyc(); cyc();
        n_checks++;
        if (tick !== 1'b1 || remain[31:24] !== 8'd6)
            $display("FAIL prio_next_tick tick=%b remain=%0d expected 1/6", tick, remain[31:24]);
        else n_pass++;
        cyc();
        n_checks++;
        if (remain[31:24] !== 8'd5) $display("FAIL prio_decrement got %0d expected 5", remain[31:24]);
        else n_pass++;
        cancel = 4'b1000;
        cyc(); cancel = 4'b0;
        n_checks++;
        if (busy !== 4'b0 || expire !== 4'b0 || remain !== 32'h0)
            $display("FAIL prio_cleanup busy=%b expire=%b remain=%h expected zeros", busy, expire, remain);
        else n_pass++;
        cyc();
    endtask

    task automatic test_reload();
        logic [7:0] e_rem;
        logic [3:0] e_exp;
        dur[7:0] = 8'd2; start = 4'b0001;
        cyc(); start = 4'b0;
        cyc(); cyc(); cyc(); cyc();
        n_checks++;
        if (remain[7:0] !== 8'd1) $display("FAIL reload_pre got %0d expected 1", remain[7:0]);
        else n_pass++;
        dur[7:0] = 8'd3; start = 4'b0001;
        for (int k = 6; k <= 18; k++) begin
            cyc();
            start = 4'b0;
            e_rem = (k <= 8) ? 8'd3 : ((k <= 12) ? 8'd2 : ((k <= 16) ? 8'd1 : 8'd0));
            e_exp = (k == 17) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (remain[7:0] !== e_rem || expire !== e_exp || busy[0] !== (k < 17))
                $display("FAIL reload k=%0d remain=%0d expire=%b busy=%b expected %0d/%b/%b",
                         k, remain[7:0], expire, busy[0], e_rem, e_exp, (k < 17));
            else n_pass++;
        end
    endtask

    task automatic test_concurrency();
        logic [3:0] e_exp, e_busy;
        logic       e_tick;
        dur[7:0] = 8'd1; dur[15:8] = 8'd1; start = 4'b0011;
        for (int k = 1; k <= 13; k++) begin
            cyc();
            start = 4'b0;
            e_exp  = (k == 5) ? 4'b0011 : 4'b0000;
            e_busy = (k < 5) ? 4'b0011 : 4'b0000;
            e_tick = (k == 4) || (k == 8) || (k == 12);
            n_checks++;
            if (expire !== e_exp || busy !== e_busy || tick !== e_tick)
                $display("FAIL concurrency k=%0d expire=%b busy=%b tick=%b expected %b/%b/%b",
                         k, expire, busy, tick, e_exp, e_busy, e_tick);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        dur[7:0] = 8'd3; start = 4'b0001;
        cyc(); start = 4'b0;
        cyc(); cyc(); cyc(); cyc();
        n_checks++;
        if (remain[7:0] !== 8'd2 || busy[0] !== 1'b1)
            $display("FAIL rstmid_pre remain=%0d busy=%b expected 2/1", remain[7:0], busy[0]);
        else n_pass++;
        rst = 1'b1; dur[15:8] = 8'd4; start = 4'b0010;
        cyc(); rst = 1'b0; start = 4'b0;
        n_checks++;
        if ({busy, expire, remain, tick} !== 41'h0)
            $display("FAIL rstmid_outputs busy=%b expire=%b remain=%h tick=%b expected all zero", busy, expire, remain, tick);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (expire !== 4'b0 || busy !== 4'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL rstmid_quiet got %0d active cycles expected 0", bad);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        cyc();
        test_zero();
        test_priority();
        test_reload();
        cyc();
        test_concurrency();
        cyc();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
